// File: rtl/tinker_fetch.sv
// tinker_fetch: instruction fetch unit. It keeps the fetch PC, issues word reads
//   to instruction memory and buffers the returned {word, pc} pairs in order.
// Latency: a response in cycle N is presented to the decoder in cycle N+1 when the
//   buffer is empty. The first request goes out in the first cycle after reset and
//   in the cycle after a redirect.
// Backpressure: a request is issued only while a buffer slot is free for its
//   response, so the buffer never overflows. The head is held while instr_ready
//   is low. Responses cannot be stalled.
// Ports: clk/reset_n (asynchronous, active-low); req_valid/req_ready/req_addr
//   (memory request); resp_valid/resp_data (in-order responses);
//   instr_valid/instr_ready/instr/instr_pc (decoder side);
//   redirect_valid/redirect_pc (flush and restart); fault (sticky misalignment).
// Option: TINKER_FETCH_ALIGN_CHECK_EN. When it is defined, a misaligned redirect
//   sets fault and halts fetch until reset. When it is not defined, the redirect
//   target is word-aligned by clearing its two low bits.

// Small synchronous FIFO with a flush input.
// Latency: data pushed in cycle N is at the head in cycle N+1.
// Backpressure: a push is ignored when the FIFO is full and not popping, and it is
//   also ignored when flush is high. A pop takes effect only when the FIFO is not empty.
module tinker_fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_rdy && pop_vld;
  assign do_push = push_vld && !flush && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // A pop that coincides with the flush still completes, because the
      // consumer has already taken the head.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

module tinker_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h2000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t         state;
  logic [63:0]    fetch_pc;
  logic [CW-1:0]  outstanding;
  logic [15:0]    drop_cnt;
  logic [CW-1:0]  fifo_count;
  logic [95:0]    head_dat;
  logic           req_fire;
  logic           resp_drop;
  logic           resp_push;
  logic [63:0]    resp_pc;
  logic [63:0]    target_pc;
  logic           misaligned;

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  assign target_pc  = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[63:2], 2'b00};
  assign misaligned     = 1'b0;
`endif

  // Every accepted request has a reserved buffer slot. Gating with reset_n keeps
  // req_valid low for the whole time reset is asserted.
  assign req_valid = reset_n && (state == RUN) && !redirect_valid &&
                     (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH));
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;

  // Stale responses (from before a redirect) are the oldest ones in flight,
  // so they are consumed first.
  assign resp_drop = resp_valid && (drop_cnt != '0);
  assign resp_push = resp_valid && (drop_cnt == '0) && (outstanding != '0);

  // Requests since the last redirect are sequential. The oldest one in flight
  // therefore sits 4*outstanding bytes behind fetch_pc.
  assign resp_pc = fetch_pc - {{(62-CW){1'b0}}, outstanding, 2'b00};

  tinker_fetch_fifo #(
    .WIDTH (96),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect_valid || (state == HALT)),
    .push_vld (resp_push),
    .push_dat ({resp_data, resp_pc}),
    .pop_vld  (instr_valid),
    .pop_rdy  (instr_ready),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  assign instr    = head_dat[95:64];
  assign instr_pc = head_dat[63:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      fault       <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // req_valid is low in this cycle, so no new request joins the in-flight
      // set. A response arriving in this cycle is discarded with the others.
      fetch_pc    <= target_pc;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + 16'(outstanding) - 16'(resp_drop || resp_push);
      if ((state == RUN) && misaligned) begin
        state <= HALT;
        fault <= 1'b1;
      end
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 64'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_push);
      drop_cnt    <= drop_cnt - 16'(resp_drop);
    end
  end
endmodule
